// File: rtl/zigzag_buffer.sv
// -----------------------------------------------------------------------------
// zigzag_buffer
// Ping-pong reorder buffer between a DCT and an entropy coder. Coefficients
// arrive in raster order (row-major, 0..63) and leave in JPEG zigzag order.
// Two 64-entry banks let one block fill while the other drains, so a
// continuous input stream is sustained at one sample per cycle when the
// consumer keeps up.
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous, active-high reset
//   y          input coefficient, raster order
//   valid      y carries a new coefficient this cycle (no backpressure)
//   out_data   coefficient in zigzag order (0 while out_valid is low)
//   out_valid  out_data holds a coefficient
//   out_ready  consumer accepts out_data this cycle
//   out_last   out_data is the final coefficient of the block
//   overflow   sticky: an input sample was dropped because no bank was free
//
// Bank states
//   state   | meaning
//   EMPTY   | free, no samples written yet
//   FILLING | write side is part-way through a block
//   FULL    | complete block, owned by the read side until drained
// -----------------------------------------------------------------------------
module zigzag_buffer #(
    parameter int DATA_WIDTH  = 8,
    parameter int BLOCK_DEPTH = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] y,
    input  logic                  valid,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic                  overflow
);

    localparam int CNT_W = $clog2(BLOCK_DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLOCK_DEPTH - 1);

    typedef enum logic [1:0] {
        EMPTY   = 2'd0,
        FILLING = 2'd1,
        FULL    = 2'd2
    } bank_state_t;

    // Zigzag position -> raster index
    localparam logic [CNT_W-1:0] ZZ [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    logic [DATA_WIDTH-1:0] mem [2*BLOCK_DEPTH];

    bank_state_t      bank_st   [2];
    bank_state_t      bank_st_n [2];
    logic             wr_bank, wr_bank_n;
    logic             rd_bank, rd_bank_n;
    logic [CNT_W-1:0] wr_cnt,  wr_cnt_n;
    logic [CNT_W-1:0] rd_cnt,  rd_cnt_n;
    logic             overflow_n;

    logic wr_accept;
    logic wr_drop;
    logic rd_xfer;

    assign wr_accept = valid && (bank_st[wr_bank] != FULL);
    assign wr_drop   = valid && (bank_st[wr_bank] == FULL);
    assign rd_xfer   = out_valid && out_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bank_st[0] <= EMPTY;
            bank_st[1] <= EMPTY;
            wr_bank    <= 1'b0;
            rd_bank    <= 1'b0;
            wr_cnt     <= '0;
            rd_cnt     <= '0;
            overflow   <= 1'b0;
        end else begin
            bank_st[0] <= bank_st_n[0];
            bank_st[1] <= bank_st_n[1];
            wr_bank    <= wr_bank_n;
            rd_bank    <= rd_bank_n;
            wr_cnt     <= wr_cnt_n;
            rd_cnt     <= rd_cnt_n;
            overflow   <= overflow_n;
        end
    end

    // A read only happens from a FULL bank and a write only into a non-FULL
    // bank, so the two sides never touch the same bank in one cycle and both
    // updates can be applied independently.
    always_comb begin
        bank_st_n[0] = bank_st[0];
        bank_st_n[1] = bank_st[1];
        wr_bank_n    = wr_bank;
        rd_bank_n    = rd_bank;
        wr_cnt_n     = wr_cnt;
        rd_cnt_n     = rd_cnt;
        overflow_n   = overflow | wr_drop;

        if (wr_accept) begin
            wr_cnt_n = wr_cnt + 1'b1;
            if (wr_cnt == CNT_MAX) begin
                bank_st_n[wr_bank] = FULL;
                wr_bank_n          = ~wr_bank;
            end else begin
                bank_st_n[wr_bank] = FILLING;
            end
        end

        if (rd_xfer) begin
            rd_cnt_n = rd_cnt + 1'b1;
            if (rd_cnt == CNT_MAX) begin
                bank_st_n[rd_bank] = EMPTY;
                rd_bank_n          = ~rd_bank;
            end
        end
    end

    // Storage is not reset; stale contents are hidden by gating out_data.
    always_ff @(posedge clk) begin
        if (wr_accept) begin
            mem[{wr_bank, wr_cnt}] <= y;
        end
    end

    assign out_valid = (bank_st[rd_bank] == FULL);
    assign out_last  = out_valid && (rd_cnt == CNT_MAX);
    assign out_data  = out_valid ? mem[{rd_bank, ZZ[rd_cnt]}] : '0;

endmodule

// File: tb/tb_zigzag_buffer.sv
module tb_zigzag_buffer;

    logic       clk;
    logic       rst;
    logic [7:0] y;
    logic       valid;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       overflow;

    int checks = 0;
    int errors = 0;
    int k;

    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10,
        17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34,
        27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36,
        29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46,
        53, 60, 61, 54, 47, 55, 62, 63
    };

    zigzag_buffer #(.DATA_WIDTH(8), .BLOCK_DEPTH(64)) dut (
        .clk       (clk),
        .rst       (rst),
        .y         (y),
        .valid     (valid),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout observed running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst       = 1'b1;
        y         = '0;
        valid     = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data",  32'(out_data),  0);
        chk("rst_last",  32'(out_last),  0);
        chk("rst_ovf",   32'(overflow),  0);
        tick();
        tick();
        rst = 1'b0;

        // single block, raster 0..63
        out_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1;
            y     = 8'(i);
            if (i == 63) chk("sb_valid_before", 32'(out_valid), 0);
            tick();
        end
        valid = 1'b0;
        k = 0;
        for (int c = 0; c < 80 && k < 64; c++) begin
            chk("sb_valid", 32'(out_valid), 1);
            chk("sb_data",  32'(out_data),  32'(zz[k]));
            chk("sb_last",  32'(out_last),  32'(k == 63));
            k++;
            tick();
        end
        chk("sb_count", 32'(k), 64);
        chk("sb_valid_after", 32'(out_valid), 0);

        // backpressure, ready pattern 1,0,0,1,0,0,...
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1;
            y     = 8'(64 + i);
            tick();
        end
        valid = 1'b0;
        k = 0;
        for (int c = 0; c < 200 && k < 64; c++) begin
            out_ready = (c % 3 == 0);
            chk("bp_valid", 32'(out_valid), 1);
            chk("bp_data",  32'(out_data),  32'(64 + zz[k]));
            chk("bp_last",  32'(out_last),  32'(k == 63));
            if (out_ready) k++;
            tick();
        end
        chk("bp_count", 32'(k), 64);
        chk("bp_valid_after", 32'(out_valid), 0);

        // back-to-back: 192 samples, ready held high
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 300 && k < 192; c++) begin
            valid = (c < 192);
            y     = 8'(c);
            if (out_valid) begin
                chk("b2b_data", 32'(out_data), 32'((k / 64) * 64 + zz[k % 64]));
                chk("b2b_last", 32'(out_last), 32'(k % 64 == 63));
                k++;
            end
            tick();
        end
        valid = 1'b0;
        chk("b2b_count", 32'(k), 192);
        chk("b2b_ovf", 32'(overflow), 0);
        chk("b2b_valid_after", 32'(out_valid), 0);

        // overflow: three blocks with consumer stalled
        out_ready = 1'b0;
        for (int i = 0; i < 192; i++) begin
            valid = 1'b1;
            y     = 8'(i);
            tick();
            if (i == 127) chk("ovf_before", 32'(overflow), 0);
            if (i == 128) chk("ovf_set",    32'(overflow), 1);
        end
        valid     = 1'b0;
        out_ready = 1'b1;
        k = 0;
        for (int c = 0; c < 140 && k < 128; c++) begin
            chk("ovf_valid", 32'(out_valid), 1);
            chk("ovf_data",  32'(out_data),  32'((k / 64) * 64 + zz[k % 64]));
            chk("ovf_last",  32'(out_last),  32'(k % 64 == 63));
            k++;
            tick();
        end
        chk("ovf_count", 32'(k), 128);
        chk("ovf_no_block3", 32'(out_valid), 0);
        chk("ovf_sticky",    32'(overflow),  1);

        // reset during 30th sample of block 2 while block 1 drains
        out_ready = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1;
            y     = 8'(i);
            tick();
        end
        out_ready = 1'b1;
        for (int j = 0; j < 29; j++) begin
            valid = 1'b1;
            y     = 8'(64 + j);
            chk("rm_data", 32'(out_data), 32'(zz[j]));
            tick();
        end
        valid = 1'b1;
        y     = 8'(93);
        #2;
        rst = 1'b1;
        #1;
        chk("rm_valid", 32'(out_valid), 0);
        chk("rm_data0", 32'(out_data),  0);
        chk("rm_last",  32'(out_last),  0);
        chk("rm_ovf",   32'(overflow),  0);
        tick();
        rst   = 1'b0;
        valid = 1'b0;
        for (int i = 0; i < 64; i++) begin
            valid = 1'b1;
            y     = 8'(192 + i);
            chk("rm_fill_valid", 32'(out_valid), 0);
            tick();
        end
        valid = 1'b0;
        k = 0;
        for (int c = 0; c < 80 && k < 64; c++) begin
            chk("rm_out_valid", 32'(out_valid), 1);
            chk("rm_out_data",  32'(out_data),  32'(192 + zz[k]));
            chk("rm_out_last",  32'(out_last),  32'(k == 63));
            k++;
            tick();
        end
        chk("rm_count", 32'(k), 64);
        chk("rm_valid_after", 32'(out_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/zigzag_buffer.md
ZIGZAG_BUFFER -- requirements
Module: zigzag_buffer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of each coefficient sample.
REQ-002 SHALL have parameter BLOCK_DEPTH, fixed at 64, the number of coefficients per 8x8 block; no other value is supported.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 y  input  DATA_WIDTH  DCT coefficient, raster order (row-major, index 0..63).
REQ-006 valid  input  1  y is a new coefficient this cycle; there is no backpressure toward the DCT.
REQ-007 out_data  output  DATA_WIDTH  coefficient in zigzag order.
REQ-008 out_valid  output  1  out_data holds a coefficient.
REQ-009 out_ready  input  1  consumer accepts out_data this cycle.
REQ-010 out_last  output  1  out_data is the 64th (final) coefficient of a block.
REQ-011 overflow  output  1  sticky: at least one input sample has been dropped.

Function
REQ-012 SHALL hold two 64-entry register banks (ping-pong); each bank is in one of three states: EMPTY, FILLING, or FULL.
REQ-013 Write side: write pointer wr_bank plus 6-bit wr_cnt; on valid with wr_bank not FULL, store y at index wr_cnt and increment wr_cnt.
REQ-014 When wr_cnt==63 and the write is accepted, the bank SHALL become FULL, wr_cnt SHALL wrap to 0 and wr_bank SHALL toggle.
REQ-015 valid while wr_bank is FULL SHALL drop the sample: no write, no counter change, overflow set to 1 and held until reset.
REQ-016 Read side: rd_bank plus 6-bit rd_cnt; out_valid=1 exactly when rd_bank is FULL.
REQ-017 out_data SHALL equal rd_bank[ZZ(rd_cnt)], where ZZ is the standard JPEG zigzag table: 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5,...,46,53,60,61,54,47,55,62,63.
REQ-018 A transfer SHALL occur on out_valid & out_ready and increment rd_cnt; with out_ready=0, out_data, out_valid and out_last SHALL hold stable.
REQ-019 out_last = out_valid & (rd_cnt==63); a transfer with out_last SHALL set rd_bank to EMPTY, wrap rd_cnt to 0 and toggle rd_bank.
REQ-020 Latency: a bank whose 64th write is accepted in cycle N SHALL show out_valid=1 in cycle N+1 if it is rd_bank.
REQ-021 Simultaneous events: the final write into one bank and the final read from the other bank in the same cycle SHALL both take effect.
REQ-022 A bank released by the read side in cycle N SHALL accept writes from cycle N+1.
REQ-023 With out_ready held at 1, a continuous valid stream SHALL never overflow; sustained throughput is 1 sample per cycle.
REQ-024 Arithmetic: only the counters do arithmetic, mod-64 wrap; data SHALL pass through unmodified, with no sign extension or truncation.

Reset
REQ-025 rst=1 SHALL immediately force both banks EMPTY, wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, out_valid=0, out_last=0, overflow=0, out_data=0.
REQ-026 Bank contents need not be cleared; after reset they SHALL never be observable on out_data.
REQ-027 Reset asserted mid-block SHALL discard the partial and complete blocks; the first valid after deassertion is raster index 0.

Verification
REQ-028 Reset: assert rst asynchronously mid-cycle -> all outputs 0 before the next clk edge; overflow=0.
REQ-029 Single block: y = 0..63 on 64 consecutive valid cycles, out_ready=1 -> out_valid rises the cycle after the 64th input; out_data = 0,1,8,16,9,2,...,62,63; out_last only on 63; out_valid falls afterwards.
REQ-030 Backpressure: same block, out_ready toggled 1,0,0,1,... -> no coefficient repeated or skipped; out_data stable while out_ready=0.
REQ-031 Back-to-back: 192 consecutive valid samples (3 blocks, values 0..191), out_ready=1 -> 192 zigzag outputs in block order; overflow stays 0.
REQ-032 Overflow: 3 blocks with out_ready=0 -> blocks 1-2 stored; overflow=1 at the first sample of block 3; on release, blocks 1-2 come out intact and block 3 is absent.
REQ-033 Reset mid-operation: rst during the 30th sample of block 2 while block 1 drains -> out_valid=0 immediately; the next 64 samples come out as a correct single block.
